arb8way16: RTL and testbench
============================

Name: arb8way16

Overview:
- Round-robin arbiter and sequencer that shares one mux8way16 datapath among eight 16-bit requesters.
- Picks a winner, drives the mux select, and captures the selected word into a registered output with a valid/ready handshake.
- Grants a winner up to MAX_BURST back-to-back transfers before forcing rotation.
- Sits between the eight producer ports and a single downstream consumer.

Parameters:
- MAX_BURST, 4, maximum consecutive transfers granted to one owner before re-arbitration; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i pairs with data input i (a=0 ... h=7).
- a, b, c, d, e, f, g, h  input  16 each  requester data words.
- gnt  output  8  one-hot, one-cycle acknowledge that requester i's word was captured this cycle.
- sel  output  3  index of the current or last owner; drives the mux8way16 select.
- out  output  16  registered output word.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accepts out when out_valid && out_ready.
- busy  output  1  high in OWN state.

Behaviour:
- Reset (async, active-high): out=0, out_valid=0, gnt=0, sel=0, state=IDLE, burst_cnt=0, last=7, so requester 0 has top priority after reset. Any in-flight word is discarded.
- slot_free = !out_valid || out_ready. A transfer can occur only when slot_free.
- Winner search: circular priority starting at last+1, wrapping at 7 back to 0, ending at last (last has lowest priority). Result is the first i with req[i]=1.
- IDLE:
  - If slot_free and |req: transfer from winner w; sel<=w; last<=w; burst_cnt<=1; go to OWN.
  - Else stay. out_valid clears if out_ready and there is no transfer.
- OWN (owner = sel):
  - If !slot_free: hold everything; gnt=0.
  - Elif req[owner] && burst_cnt<MAX_BURST: transfer from owner; burst_cnt++.
  - Elif |req: transfer from winner w. This may be the owner itself if it is the only requester. sel<=w; last<=w; burst_cnt<=1.
  - Else go to IDLE; out_valid clears on out_ready.
- Transfer (single cycle):
  - out <= data[w] taken through the mux8way16 with select = w.
  - out_valid <= 1.
  - gnt[w]=1 combinationally in the same cycle, so the requester may advance its data or drop req next cycle.
- Latency: word presented at edge N with slot_free appears on out after edge N. Throughput is 1 word/cycle while out_ready=1.
- Simultaneous consume and transfer: out_ready=1 with a transfer replaces out with the new word; out_valid stays 1.
- A requester dropping req while it owns the grant releases ownership immediately. Other requesters may win that same cycle.
- sel holds its value in IDLE.
- burst_cnt is 4 bits and never exceeds MAX_BURST.
- gnt is 0 whenever no transfer occurs, including during reset.

Decomposition:
- Shared package/include: N_REQ=8, SEL_W=3, DATA_W=16, and state encodings IDLE=1'b0, OWN=1'b1.
- Sub-module: reuse the existing mux8way16 for the datapath select.
- Winner search is one combinational function (priority rotate by last+1), kept inside arb8way16.

Test Plan:
- Reset then req=8'b0000_0001, a=16'h1111, out_ready=1 -> gnt=8'h01 next cycle; out=16'h1111, out_valid=1, sel=0, busy=1.
- Continuous requests: req=8'hFF with all outputs ready, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,2,... with out tracking a..h in that order.
- Backpressure: out_ready=0 after first capture -> out holds, gnt=0, burst_cnt frozen. Releasing out_ready resumes with the next word in the cycle of acceptance.
- Rotation fairness: req=8'b1000_0001 with MAX_BURST=1 -> alternating gnt 0,7,0,7; sel alternates 0/7.
- Sole requester at burst limit: req=8'b0001_0000 held for 6 cycles -> gnt[4] every cycle, burst_cnt wraps 1..4,1, no idle bubble.
- Async reset asserted mid-burst (out_valid=1, sel=5) -> out=0, out_valid=0, gnt=0, sel=0 immediately. After deassert with req=8'hFF, requester 0 wins first.

Source files
------------

// File: rtl/arb8way16_pkg.sv
// Shared sizes and FSM encoding for the eight-way round-robin arbiter.
package arb8way16_pkg;
  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;
endpackage

// File: rtl/arb8way16_if.sv
// Producer-side request/data bus plus the single downstream valid/ready port.
interface arb8way16_if;
  import arb8way16_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic [N_REQ-1:0]  gnt;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  req, a, b, c, d, e, f, g, h, out_ready,
    output gnt, sel, out, out_valid, busy
  );

  modport master (
    output req, a, b, c, d, e, f, g, h, out_ready,
    input  gnt, sel, out, out_valid, busy
  );
endinterface

// File: rtl/arb8way16_mux8way16.sv
// Eight-input, 16-bit wide word select shared by all requesters.
module mux8way16
  import arb8way16_pkg::*;
(
  input  logic [DATA_W-1:0] a, b, c, d, e, f, g, h,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out
);
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end
endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter with burst limit feeding one registered valid/ready output.
module arb8way16
  import arb8way16_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         reset,
  arb8way16_if.slave  bus
);
  // Circular priority: last+1 first, last itself lowest.
  function automatic logic [SEL_W-1:0] find_winner(input logic [N_REQ-1:0] r,
                                                   input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] w;
    logic             found;
    w     = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel_p1, last_p1;
  logic [CNT_W-1:0]  burst_cnt, burst_n;
  logic [DATA_W-1:0] out_p1, mux_out;
  logic              vld_p1;
  logic              slot_free, xfer, new_owner;
  logic [SEL_W-1:0]  winner, xfer_idx;

  assign slot_free = !vld_p1 || bus.out_ready;
  assign winner    = find_winner(bus.req, last_p1);

  always_comb begin
    state_n   = state;
    burst_n   = burst_cnt;
    xfer      = 1'b0;
    new_owner = 1'b0;
    xfer_idx  = sel_p1;
    if (state == IDLE) begin
      if (slot_free && |bus.req) begin
        xfer      = 1'b1;
        new_owner = 1'b1;
        xfer_idx  = winner;
        burst_n   = CNT_W'(1);
        state_n   = OWN;
      end
    end else if (slot_free) begin
      if (bus.req[sel_p1] && burst_cnt < CNT_W'(MAX_BURST)) begin
        xfer    = 1'b1;
        burst_n = burst_cnt + CNT_W'(1);
      end else if (|bus.req) begin
        // Sole requester at its limit re-wins here, so no idle bubble.
        xfer      = 1'b1;
        new_owner = 1'b1;
        xfer_idx  = winner;
        burst_n   = CNT_W'(1);
      end else begin
        state_n = IDLE;
      end
    end
  end

  mux8way16 u_mux (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .e   (bus.e),
    .f   (bus.f),
    .g   (bus.g),
    .h   (bus.h),
    .sel (xfer_idx),
    .out (mux_out)
  );

  // Stage p1: captured word, owner and burst bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_p1    <= '0;
      last_p1   <= SEL_W'(N_REQ - 1);
      burst_cnt <= '0;
      out_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      vld_p1    <= xfer || (vld_p1 && !bus.out_ready);
      if (xfer)
        out_p1 <= mux_out;
      if (new_owner) begin
        sel_p1  <= xfer_idx;
        last_p1 <= xfer_idx;
      end
    end
  end

  assign bus.gnt       = (xfer && !reset) ? (N_REQ'(1) << xfer_idx) : '0;
  assign bus.sel       = sel_p1;
  assign bus.out       = out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.busy      = (state == OWN);
endmodule

// File: tb/tb_arb8way16.sv
// Directed bench for arb8way16: vector table plus burst, fairness and reset sequences.
module tb_arb8way16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  arb8way16_if bus0();
  arb8way16_if bus1();

  arb8way16 #(.MAX_BURST(4)) dut  (.clk(clk), .reset(reset), .bus(bus0));
  arb8way16 #(.MAX_BURST(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic        rdy;
    logic [7:0]  gnt;
    logic [15:0] out;
    logic        vld;
    logic [2:0]  sel;
    logic        busy;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [15:0] word(input int idx);
    return 16'(16'h1111 * (idx + 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reset both DUTs, check reset state, release at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    bus0.req = '0;
    bus1.req = '0;
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", bus0.out, 16'h0);
    chk("rst_vld", bus0.out_valid, 0);
    chk("rst_gnt", bus0.gnt, 0);
    chk("rst_sel", bus0.sel, 0);
    chk("rst_busy", bus0.busy, 0);
    reset = 1'b0;
  endtask

  initial begin
    bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.c = 16'h3333; bus0.d = 16'h4444;
    bus0.e = 16'h5555; bus0.f = 16'h6666; bus0.g = 16'h7777; bus0.h = 16'h8888;
    bus1.a = 16'h1111; bus1.b = 16'h2222; bus1.c = 16'h3333; bus1.d = 16'h4444;
    bus1.e = 16'h5555; bus1.f = 16'h6666; bus1.g = 16'h7777; bus1.h = 16'h8888;
    bus0.req = '0; bus1.req = '0;
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;

    //                req    rdy   gnt    out       vld   sel   busy
    tbl[0]  = '{8'h01, 1'b1, 8'h01, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[1]  = '{8'hFF, 1'b1, 8'h01, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[2]  = '{8'hFF, 1'b1, 8'h01, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[3]  = '{8'hFF, 1'b1, 8'h01, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[4]  = '{8'hFF, 1'b1, 8'h02, 16'h2222, 1'b1, 3'd1, 1'b1};
    tbl[5]  = '{8'hFF, 1'b0, 8'h00, 16'h2222, 1'b1, 3'd1, 1'b1};
    tbl[6]  = '{8'hFF, 1'b0, 8'h00, 16'h2222, 1'b1, 3'd1, 1'b1};
    tbl[7]  = '{8'hFF, 1'b1, 8'h02, 16'h2222, 1'b1, 3'd1, 1'b1};
    tbl[8]  = '{8'h02, 1'b1, 8'h02, 16'h2222, 1'b1, 3'd1, 1'b1};
    tbl[9]  = '{8'h04, 1'b1, 8'h04, 16'h3333, 1'b1, 3'd2, 1'b1};
    tbl[10] = '{8'h00, 1'b1, 8'h00, 16'h3333, 1'b0, 3'd2, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 8'h00, 16'h3333, 1'b0, 3'd2, 1'b0};
    tbl[12] = '{8'h81, 1'b0, 8'h80, 16'h8888, 1'b1, 3'd7, 1'b1};
    tbl[13] = '{8'h81, 1'b1, 8'h80, 16'h8888, 1'b1, 3'd7, 1'b1};
    tbl[14] = '{8'h01, 1'b1, 8'h01, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[15] = '{8'h00, 1'b0, 8'h00, 16'h1111, 1'b1, 3'd0, 1'b1};
    tbl[16] = '{8'h00, 1'b1, 8'h00, 16'h1111, 1'b0, 3'd0, 1'b0};

    // Vector table, MAX_BURST=4.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus0.req = tbl[i].req;
      bus0.out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_gnt", i), bus0.gnt, tbl[i].gnt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out", i), bus0.out, tbl[i].out);
      chk($sformatf("v%0d_vld", i), bus0.out_valid, tbl[i].vld);
      chk($sformatf("v%0d_sel", i), bus0.sel, tbl[i].sel);
      chk($sformatf("v%0d_busy", i), bus0.busy, tbl[i].busy);
      @(negedge clk);
    end

    // All requesting, consumer always ready: four words per owner, in order.
    do_reset();
    bus0.req = 8'hFF;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk($sformatf("ff%0d_gnt", k), bus0.gnt, 8'h01 << ((k / 4) % 8));
      @(posedge clk); #1;
      chk($sformatf("ff%0d_out", k), bus0.out, word((k / 4) % 8));
      chk($sformatf("ff%0d_sel", k), bus0.sel, (k / 4) % 8);
      @(negedge clk);
    end

    // MAX_BURST=1 fairness between requesters 0 and 7.
    do_reset();
    bus1.req = 8'b1000_0001;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_gnt", k), bus1.gnt, (k % 2 == 0) ? 8'h01 : 8'h80);
      @(posedge clk); #1;
      chk($sformatf("rr%0d_sel", k), bus1.sel, (k % 2 == 0) ? 0 : 7);
      chk($sformatf("rr%0d_out", k), bus1.out, (k % 2 == 0) ? 16'h1111 : 16'h8888);
      @(negedge clk);
    end
    bus1.req = '0;

    // Sole requester past its burst limit keeps the grant with no bubble.
    do_reset();
    bus0.req = 8'b0001_0000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("solo%0d_gnt", k), bus0.gnt, 8'h10);
      @(posedge clk); #1;
      chk($sformatf("solo%0d_cnt", k), dut.burst_cnt, (k % 4) + 1);
      chk($sformatf("solo%0d_busy", k), bus0.busy, 1);
      chk($sformatf("solo%0d_out", k), bus0.out, 16'h5555);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of requester 5's burst.
    do_reset();
    bus0.req = 8'hFF;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk);
      if (k < 20) @(negedge clk);
    end
    #1;
    chk("mid_sel", bus0.sel, 5);
    chk("mid_vld", bus0.out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_out", bus0.out, 16'h0);
    chk("arst_vld", bus0.out_valid, 0);
    chk("arst_gnt", bus0.gnt, 0);
    chk("arst_sel", bus0.sel, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_gnt", bus0.gnt, 8'h01);
    @(posedge clk); #1;
    chk("post_out", bus0.out, 16'h1111);
    chk("post_sel", bus0.sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
